// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: load opcodes, side-bus default width, cancel states and the MS register layout
package mem_stage_pkg;
   localparam logic [2:0] LD_NONE = 3'd0;
   localparam logic [2:0] LD_B    = 3'd1;
   localparam logic [2:0] LD_H    = 3'd2;
   localparam logic [2:0] LD_W    = 3'd3;
   localparam logic [2:0] LD_BU   = 3'd4;
   localparam logic [2:0] LD_HU   = 3'd5;
   localparam int SIDE_WD_DEF = 128;
   typedef enum logic {C_IDLE = 1'b0, C_DROP = 1'b1} cancel_e;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] result;
      logic [4:0]  dest;
      logic        gr_we;
      logic [2:0]  ld_op;
      logic        mem_req;
      logic        ex;
   } ms_reg_t;
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: picks the addressed byte/halfword of a load word and extends it
module mem_load_align import mem_stage_pkg::*; (
   input  logic [2:0]  ld_op,
   input  logic [1:0]  addr,
   input  logic [31:0] rdata,
   output logic [31:0] result
);
   logic [7:0]  b;
   logic [15:0] h;
   always_comb begin
      b = rdata[{addr, 3'b000} +: 8];
      h = addr[1] ? rdata[31:16] : rdata[15:0];
      result = (ld_op == LD_W)  ? rdata :
               (ld_op == LD_B)  ? {{24{b[7]}}, b} :
               (ld_op == LD_BU) ? {24'd0, b} :
               (ld_op == LD_H)  ? {{16{h[15]}}, h} :
               (ld_op == LD_HU) ? {16'd0, h} : rdata;
   end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: LoongArch MEM stage (EX->MS register, data_ok wait, load align, flush cancel).
// MS_RDATA_BUF_EN adds a load-data buffer so WB back-pressure can coexist with data_ok.
module mem_stage import mem_stage_pkg::*; #(
   parameter int SIDE_WD = SIDE_WD_DEF
) (
   input  logic               clk,
   input  logic               resetn,
   output logic               ms_allowin,
   input  logic               es_to_ms_valid,
   input  logic [31:0]        es_pc,
   input  logic [31:0]        es_result,
   input  logic [4:0]         es_dest,
   input  logic               es_gr_we,
   input  logic [2:0]         es_ld_op,
   input  logic               es_mem_req,
   input  logic               es_ex,
   input  logic [SIDE_WD-1:0] es_side_bus,
   input  logic               data_sram_data_ok,
   input  logic [31:0]        data_sram_rdata,
   input  logic               ws_allowin,
   input  logic               ws_flush_pipe,
   output logic               ms_to_ws_valid,
   output logic [31:0]        ms_pc,
   output logic [31:0]        ms_final_result,
   output logic [4:0]         ms_dest,
   output logic               ms_gr_we,
   output logic               ms_ex,
   output logic [SIDE_WD-1:0] ms_side_bus,
   output logic               ms_fwd_valid,
   output logic [4:0]         ms_fwd_dest,
   output logic [31:0]        ms_fwd_data,
   output logic               ms_fwd_blocked
);
   logic               ms_valid_q, ms_valid_d;
   cancel_e            cancel_q, cancel_d;
   logic               buf_valid_q, buf_valid_d;
   logic [31:0]        buf_data_q, buf_data_d;
   ms_reg_t            ms_r_q, ms_r_d;
   logic [SIDE_WD-1:0] side_q, side_d;
   logic               ready_go, load_en;
   logic [31:0]        rdata_src, load_data;

   mem_load_align u_align (
      .ld_op  (ms_r_q.ld_op),
      .addr   (ms_r_q.result[1:0]),
      .rdata  (rdata_src),
      .result (load_data)
   );

   always_comb begin
      ready_go = !ms_r_q.mem_req | (data_sram_data_ok & (cancel_q == C_IDLE)) | buf_valid_q;
      ms_allowin = !ms_valid_q | (ready_go & ws_allowin);
      ms_to_ws_valid = ms_valid_q & ready_go & !ws_flush_pipe;
      load_en = ms_allowin & es_to_ms_valid;
      ms_valid_d = ws_flush_pipe ? 1'b0 : ms_allowin ? es_to_ms_valid : ms_valid_q;
      ms_r_d = load_en ? ms_reg_t'{es_pc, es_result, es_dest, es_gr_we, es_ld_op, es_mem_req, es_ex} : ms_r_q;
      side_d = load_en ? es_side_bus : side_q;
      // a response arriving with the flush still belongs to the flushed load, so nothing is left to drop
      cancel_d = (ws_flush_pipe & ms_valid_q & ms_r_q.mem_req & !ready_go) ? C_DROP :
                 data_sram_data_ok ? C_IDLE : cancel_q;
      rdata_src = buf_valid_q ? buf_data_q : data_sram_rdata;
      ms_final_result = (ms_r_q.ld_op == LD_NONE) ? ms_r_q.result : load_data;
      ms_pc = ms_r_q.pc;
      ms_dest = ms_r_q.dest;
      ms_gr_we = ms_r_q.gr_we;
      ms_ex = ms_r_q.ex;
      ms_side_bus = side_q;
      ms_fwd_valid = ms_valid_q & ms_r_q.gr_we & (ms_r_q.dest != 5'd0);
      ms_fwd_dest = ms_r_q.dest;
      ms_fwd_data = ms_final_result;
      ms_fwd_blocked = ms_valid_q & (ms_r_q.ld_op != LD_NONE) & !ready_go;
   end

`ifdef MS_RDATA_BUF_EN
   always_comb begin
      buf_valid_d = (ws_flush_pipe | (ready_go & ws_allowin)) ? 1'b0 :
                    (ms_valid_q & ms_r_q.mem_req & data_sram_data_ok & (cancel_q == C_IDLE)) ? 1'b1 : buf_valid_q;
      buf_data_d = (!buf_valid_q & data_sram_data_ok & !ws_allowin) ? data_sram_rdata : buf_data_q;
   end
`else
   always_comb begin
      buf_valid_d = 1'b0;
      buf_data_d = buf_data_q;
   end
   a_wb_never_stalls: assert property (@(posedge clk) disable iff (!resetn) !(data_sram_data_ok && !ws_allowin));
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         ms_valid_q  <= 1'b0;
         cancel_q    <= C_IDLE;
         buf_valid_q <= 1'b0;
         ms_r_q      <= '0;
      end else begin
         ms_valid_q  <= ms_valid_d;
         cancel_q    <= cancel_d;
         buf_valid_q <= buf_valid_d;
         ms_r_q      <= ms_r_d;
      end
      side_q     <= side_d;
      buf_data_q <= buf_data_d;
   end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage with an in-order data-SRAM responder model
module tb_mem_stage;
`ifdef MS_RDATA_BUF_EN
   localparam bit BUF = 1'b1;
`else
   localparam bit BUF = 1'b0;
`endif
   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         ms_allowin, es_to_ms_valid = 1'b0;
   logic [31:0]  es_pc = '0, es_result = '0;
   logic [4:0]   es_dest = '0;
   logic         es_gr_we = 1'b0, es_mem_req = 1'b0, es_ex = 1'b0;
   logic [2:0]   es_ld_op = '0;
   logic [127:0] es_side_bus = '0;
   logic         data_sram_data_ok = 1'b0;
   logic [31:0]  data_sram_rdata = '0;
   logic         ws_allowin = 1'b1, ws_flush_pipe = 1'b0;
   logic         ms_to_ws_valid, ms_gr_we, ms_ex, ms_fwd_valid, ms_fwd_blocked;
   logic [31:0]  ms_pc, ms_final_result, ms_fwd_data;
   logic [4:0]   ms_dest, ms_fwd_dest;
   logic [127:0] ms_side_bus;

   typedef struct {
      int           id;
      logic [2:0]   ld;
      logic [31:0]  pc, res;
      logic [4:0]   dest;
      logic         we, ex;
      logic [127:0] side;
   } exp_t;
   typedef struct {
      int          id;
      logic [31:0] rd;
   } mem_t;
   exp_t expq[$];
   mem_t memq[$];
   exp_t me;
   int   next_id = 0;
   int   n_cmp = 0, n_bad = 0;

   mem_stage dut (
      .clk(clk), .resetn(resetn), .ms_allowin(ms_allowin), .es_to_ms_valid(es_to_ms_valid),
      .es_pc(es_pc), .es_result(es_result), .es_dest(es_dest), .es_gr_we(es_gr_we),
      .es_ld_op(es_ld_op), .es_mem_req(es_mem_req), .es_ex(es_ex), .es_side_bus(es_side_bus),
      .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
      .ws_allowin(ws_allowin), .ws_flush_pipe(ws_flush_pipe), .ms_to_ws_valid(ms_to_ws_valid),
      .ms_pc(ms_pc), .ms_final_result(ms_final_result), .ms_dest(ms_dest), .ms_gr_we(ms_gr_we),
      .ms_ex(ms_ex), .ms_side_bus(ms_side_bus), .ms_fwd_valid(ms_fwd_valid),
      .ms_fwd_dest(ms_fwd_dest), .ms_fwd_data(ms_fwd_data), .ms_fwd_blocked(ms_fwd_blocked)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // architectural load result: pick byte/halfword by address, extend by opcode
   function automatic logic [31:0] model(input logic [2:0] ld, input logic [31:0] a, input logic [31:0] rd);
      logic [31:0] b, h;
      b = (rd >> (8 * (a % 4))) % 256;
      h = (rd >> (16 * ((a / 2) % 2))) % 65536;
      case (ld)
         3'd1: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         3'd4: return b;
         3'd2: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         3'd5: return h;
         3'd3: return rd;
         default: return a;
      endcase
   endfunction

   function automatic bit pending(input int id);
      foreach (memq[i]) if (memq[i].id == id) return 1'b1;
      return 1'b0;
   endfunction

   // one clock cycle: drive EX/SRAM/WB inputs, check handshake outputs, update the reference model
   task automatic step(input logic v, input logic [2:0] ld, input logic [31:0] a, input logic [31:0] rd,
                       input logic mreq, input logic ex, input logic we, input logic [4:0] dest,
                       input logic fl, input logic dok, input logic wsa);
      logic alw, occ, rdy;
      exp_t e;
      @(posedge clk); #1;
      es_to_ms_valid = v && !fl;
      es_pc = $urandom;
      es_result = a;
      es_dest = dest;
      es_gr_we = we;
      es_ld_op = ld;
      es_mem_req = mreq;
      es_ex = ex;
      es_side_bus = {$urandom, $urandom, $urandom, $urandom};
      data_sram_data_ok = dok && memq.size() > 0;
      data_sram_rdata = data_sram_data_ok ? memq[0].rd : $urandom;
      ws_flush_pipe = fl;
      ws_allowin = wsa || !BUF;
      #3;
      alw = ms_allowin;
      occ = expq.size() > 0;
      rdy = !(occ && pending(expq[0].id) && !(data_sram_data_ok && memq[0].id == expq[0].id));
      check("fwd_blocked", ms_fwd_blocked, occ && expq[0].ld != 0 && !rdy);
      check("allowin", alw, !occ || (rdy && ws_allowin));
      check("wb_valid", ms_to_ws_valid, occ && rdy && !fl);
      @(negedge clk); #1;
      if (data_sram_data_ok) void'(memq.pop_front());
      if (fl && expq.size() > 0) void'(expq.pop_front());
      if (es_to_ms_valid && alw) begin
         e.id = next_id++;
         e.ld = ld;
         e.pc = es_pc;
         e.res = model(ld, a, rd);
         e.dest = dest;
         e.we = we;
         e.ex = ex;
         e.side = es_side_bus;
         expq.push_back(e);
         if (mreq) memq.push_back('{e.id, rd});
      end
   endtask

   task automatic idle(input logic dok, input logic wsa);
      step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, dok, wsa);
   endtask

   // monitor: every instruction handed to WB must match the oldest expected entry
   initial forever begin
      @(negedge clk);
      if (resetn && ms_to_ws_valid && ws_allowin) begin
         if (expq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_wb: got pc %h result %h expected no instruction", ms_pc, ms_final_result);
         end else begin
            me = expq.pop_front();
            check("wb_fields", {ms_pc, ms_final_result, ms_dest, ms_gr_we, ms_ex}, {me.pc, me.res, me.dest, me.we, me.ex});
            check("side_bus", ms_side_bus, me.side);
            check("fwd", {ms_fwd_valid, ms_fwd_dest, ms_fwd_data}, {me.we && me.dest != 5'd0, me.dest, me.res});
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {ms_to_ws_valid, ms_fwd_valid, ms_fwd_blocked, ms_gr_we, ms_ex, ms_allowin}, 6'b000001);
      @(posedge clk); #1;
      resetn = 1'b1;
      @(negedge clk);
      check("post_reset", {ms_to_ws_valid, ms_fwd_valid, ms_fwd_blocked, ms_allowin}, 4'b0001);
      // ALU op, one cycle in MS
      step(1'b1, 3'd0, 32'h1234, 32'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
      idle(1'b0, 1'b1);
      // LD_B / LD_BU with a three-cycle wait
      step(1'b1, 3'd1, 32'h1003, 32'h80FF_0000, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1);
      repeat (3) idle(1'b0, 1'b1);
      idle(1'b1, 1'b1);
      step(1'b1, 3'd4, 32'h1003, 32'h80FF_0000, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1);
      repeat (3) idle(1'b0, 1'b1);
      idle(1'b1, 1'b1);
      // halfword loads, data in the first MS cycle
      step(1'b1, 3'd2, 32'h2002, 32'h7FFE_1234, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1);
      idle(1'b1, 1'b1);
      step(1'b1, 3'd5, 32'h2000, 32'h0000_8001, 1'b1, 1'b0, 1'b1, 5'd10, 1'b0, 1'b0, 1'b1);
      idle(1'b1, 1'b1);
      // flush with a load outstanding: its late response must be discarded
      step(1'b1, 3'd3, 32'h3000, 32'h0000_DEAD, 1'b1, 1'b0, 1'b1, 5'd11, 1'b0, 1'b0, 1'b1);
      idle(1'b0, 1'b1);
      step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 3'd0, 32'h0000_5678, 32'd0, 1'b0, 1'b0, 1'b1, 5'd12, 1'b0, 1'b0, 1'b1);
      idle(1'b1, 1'b1);
      idle(1'b0, 1'b1);
      // flush and response together: the next load uses its own response directly
      step(1'b1, 3'd3, 32'h4000, 32'h0BAD_0BAD, 1'b1, 1'b0, 1'b1, 5'd13, 1'b0, 1'b0, 1'b1);
      idle(1'b0, 1'b1);
      step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
      step(1'b1, 3'd3, 32'h4004, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b1, 5'd14, 1'b0, 1'b0, 1'b1);
      idle(1'b1, 1'b1);
      idle(1'b0, 1'b1);
`ifdef MS_RDATA_BUF_EN
      step(1'b1, 3'd3, 32'h5000, 32'h1122_3344, 1'b1, 1'b0, 1'b1, 5'd15, 1'b0, 1'b0, 1'b1);
      idle(1'b1, 1'b0);
      idle(1'b0, 1'b0);
      idle(1'b0, 1'b1);
`endif
      for (int i = 0; i < 3000; i++) begin
         logic [2:0] ld;
         logic ex, mreq, fl;
         ld = ($urandom_range(0, 9) < 5) ? 3'($urandom_range(1, 5)) : 3'd0;
         ex = (ld == 3'd0) && ($urandom_range(0, 7) == 0);
         mreq = (ld != 3'd0) || (!ex && $urandom_range(0, 3) == 0);
         fl = ($urandom_range(0, 15) == 0) && (memq.size() < 2);
         step(1'($urandom_range(0, 3) != 0), ld, $urandom, $urandom, mreq, ex, 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 31)), fl, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) != 0));
      end
      for (int k = 0; k < 100 && (expq.size() > 0 || memq.size() > 0); k++) idle(1'b1, 1'b1);
      check("drained", {32'(expq.size()), 32'(memq.size())}, 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
